// File: rtl/debug_dump_sequencer_pkg.sv
// Shared types and constants for the debug dump sequencer.
// The checksum trailer is built only when DUMP_CHECKSUM_EN is defined.
package debug_dump_sequencer_pkg;

  localparam int RF_BITS     = 1024;
  localparam int IF_ID_BITS  = 64;
  localparam int ID_EX_BITS  = 128;
  localparam int EX_MEM_BITS = 128;
  localparam int MEM_WB_BITS = 64;

  // Snapshot layout, LSB first: {mem_wb, ex_mem, id_ex, if_id, rf_regs}
  localparam int RF_LSB     = 0;
  localparam int IF_ID_LSB  = RF_LSB + RF_BITS;
  localparam int ID_EX_LSB  = IF_ID_LSB + IF_ID_BITS;
  localparam int EX_MEM_LSB = ID_EX_LSB + ID_EX_BITS;
  localparam int MEM_WB_LSB = EX_MEM_LSB + EX_MEM_BITS;
  localparam int SNAP_BITS_DEF = MEM_WB_LSB + MEM_WB_BITS;

  localparam int UART_BITS_DEF        = 8;
  localparam int PROC_BITS_DEF        = 32;
  localparam int DATA_ADDRS_BITS_DEF  = 10;
  localparam int CLK_COUNTER_BITS_DEF = 32;
  localparam int MEM_WORDS_DEF        = 32;

  function automatic int bytes_of(int bits, int ubits);
    return bits / ubits;
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int HDR_BYTES  = bytes_of(CLK_COUNTER_BITS_DEF, UART_BITS_DEF);
  localparam int SNAP_BYTES = bytes_of(SNAP_BITS_DEF, UART_BITS_DEF);
  localparam int WORD_BYTES = bytes_of(PROC_BITS_DEF, UART_BITS_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HDR,
    ST_SEND_SNAP,
    ST_MEM_REQ,
    ST_MEM_LATCH,
    ST_SEND_MEM,
    ST_SEND_CSUM,
    ST_FINISH
  } dump_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LAUNCH,
    TX_WLOW,
    TX_WHIGH
  } tx_state_e;

endpackage

// File: rtl/debug_dump_sequencer_byte_shift_tx.sv
// Serialises a loaded word LSB byte first over the UART
// start/done handshake and flags completion of its last byte.
module byte_shift_tx
  import debug_dump_sequencer_pkg::*;
#(
  parameter int W  = 32,
  parameter int UB = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [W-1:0]  i_data,
  input  logic [CW-1:0] i_nbytes,
  input  logic          i_tx_done,
  output logic          o_tx_start,
  output logic [UB-1:0] o_tx_data,
  output logic          o_last_done
);

  localparam logic [CW-1:0] ONE = CW'(1);

  tx_state_e     r_state;
  tx_state_e     w_next;
  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_left;
  logic          w_advance;

  assign o_tx_data = r_shift[UB-1:0];

  always_comb begin
    w_next      = r_state;
    o_tx_start  = 1'b0;
    o_last_done = 1'b0;
    w_advance   = 1'b0;
    unique case (r_state)
      TX_IDLE: ;
      TX_LAUNCH:
        if (i_tx_done) begin
          o_tx_start = 1'b1;
          w_next     = TX_WLOW;
        end
      TX_WLOW:
        if (!i_tx_done) w_next = TX_WHIGH;
      TX_WHIGH:
        if (i_tx_done) begin
          if (r_left == ONE) begin
            o_last_done = 1'b1;
            w_next      = TX_IDLE;
          end else begin
            w_advance = 1'b1;
            w_next    = TX_LAUNCH;
          end
        end
      default: w_next = TX_IDLE;
    endcase
    // A new load may coincide with the previous last byte finishing
    if (i_load) w_next = TX_LAUNCH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= TX_IDLE;
      r_shift <= '0;
      r_left  <= '0;
    end else begin
      r_state <= w_next;
      if (i_load) begin
        r_shift <= i_data;
        r_left  <= i_nbytes;
      end else if (w_advance) begin
        r_shift <= r_shift >> UB;
        r_left  <= r_left - ONE;
      end
    end
  end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams cycle count, pipeline snapshot and data memory to the UART.
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte.
module debug_dump_sequencer
  import debug_dump_sequencer_pkg::*;
#(
  parameter int UART_BITS        = UART_BITS_DEF,
  parameter int PROC_BITS        = PROC_BITS_DEF,
  parameter int DATA_ADDRS_BITS  = DATA_ADDRS_BITS_DEF,
  parameter int CLK_COUNTER_BITS = CLK_COUNTER_BITS_DEF,
  parameter int SNAP_BITS        = SNAP_BITS_DEF,
  parameter int MEM_WORDS        = MEM_WORDS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [CLK_COUNTER_BITS-1:0] i_clk_count,
  input  logic [SNAP_BITS-1:0]        i_snapshot,
  input  logic [PROC_BITS-1:0]        i_mem_data,
  input  logic                        i_tx_done,
  output logic                        o_debug_read_data,
  output logic [DATA_ADDRS_BITS-1:0]  o_debug_read_address,
  output logic                        o_tx_start,
  output logic [UART_BITS-1:0]        o_tx_data,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int N_HDR  = bytes_of(CLK_COUNTER_BITS, UART_BITS);
  localparam int N_SNAP = bytes_of(SNAP_BITS, UART_BITS);
  localparam int N_WORD = bytes_of(PROC_BITS, UART_BITS);
  localparam int SW     = max3(SNAP_BITS, CLK_COUNTER_BITS, PROC_BITS);
  localparam int CW     = $clog2(max3(N_HDR, N_SNAP, N_WORD) + 1);
  localparam logic [DATA_ADDRS_BITS-1:0] LAST_IDX =
    DATA_ADDRS_BITS'(MEM_WORDS - 1);
  localparam logic [DATA_ADDRS_BITS-1:0] IDX_ONE = DATA_ADDRS_BITS'(1);

  dump_state_e                r_state;
  dump_state_e                w_next;
  logic [SNAP_BITS-1:0]       r_snap;
  logic [DATA_ADDRS_BITS-1:0] r_idx;
  logic                       w_load;
  logic [SW-1:0]              w_ld_data;
  logic [CW-1:0]              w_ld_n;
  logic                       w_last;
  logic                       w_idx_inc;
  logic                       w_begin;

  assign w_begin = (r_state == ST_IDLE) && i_start;

`ifdef DUMP_CHECKSUM_EN
  logic [UART_BITS-1:0] r_csum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_csum <= '0;
    else if (w_begin)    r_csum <= '0;
    else if (o_tx_start) r_csum <= r_csum ^ o_tx_data;
  end
`endif

  always_comb begin
    w_next               = r_state;
    w_load               = 1'b0;
    w_ld_data            = '0;
    w_ld_n               = '0;
    w_idx_inc            = 1'b0;
    o_debug_read_data    = 1'b0;
    o_debug_read_address = '0;
    o_done               = 1'b0;
    o_busy               = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_load    = 1'b1;
          w_ld_data = SW'(i_clk_count);
          w_ld_n    = CW'(N_HDR);
          w_next    = ST_SEND_HDR;
        end
      end
      ST_SEND_HDR:
        if (w_last) begin
          w_load    = 1'b1;
          w_ld_data = SW'(r_snap);
          w_ld_n    = CW'(N_SNAP);
          w_next    = ST_SEND_SNAP;
        end
      ST_SEND_SNAP:
        if (w_last) w_next = ST_MEM_REQ;
      ST_MEM_REQ: begin
        o_debug_read_data    = 1'b1;
        o_debug_read_address = r_idx;
        w_next               = ST_MEM_LATCH;
      end
      ST_MEM_LATCH: begin
        w_load    = 1'b1;
        w_ld_data = SW'(i_mem_data);
        w_ld_n    = CW'(N_WORD);
        w_next    = ST_SEND_MEM;
      end
      ST_SEND_MEM:
        if (w_last) begin
          if (r_idx == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
            w_load    = 1'b1;
            w_ld_data = SW'(r_csum);
            w_ld_n    = CW'(1);
            w_next    = ST_SEND_CSUM;
`else
            w_next    = ST_FINISH;
`endif
          end else begin
            w_idx_inc = 1'b1;
            w_next    = ST_MEM_REQ;
          end
        end
`ifdef DUMP_CHECKSUM_EN
      ST_SEND_CSUM:
        if (w_last) w_next = ST_FINISH;
`endif
      ST_FINISH: begin
        o_busy = 1'b0;
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        o_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_snap  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (w_begin) begin
        r_snap <= i_snapshot;
        r_idx  <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + IDX_ONE;
      end
    end
  end

  byte_shift_tx #(
    .W  (SW),
    .UB (UART_BITS),
    .CW (CW)
  ) u_tx (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_data      (w_ld_data),
    .i_nbytes    (w_ld_n),
    .i_tx_done   (i_tx_done),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .o_last_done (w_last)
  );

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer with a UART done-level model
// and a one-cycle-latency debug memory model (MEM_WORDS=4).
module tb_debug_dump_sequencer;

  localparam int NW    = 4;
  localparam int SNB   = 176;
`ifdef DUMP_CHECKSUM_EN
  localparam int TOTAL = 4 + SNB + NW * 4 + 1;
`else
  localparam int TOTAL = 4 + SNB + NW * 4;
`endif

  logic          clk;
  logic          rst;
  logic          i_start;
  logic [31:0]   i_clk_count;
  logic [1407:0] i_snapshot;
  logic [31:0]   i_mem_data;
  logic          i_tx_done;
  logic          o_debug_read_data;
  logic [9:0]    o_debug_read_address;
  logic          o_tx_start;
  logic [7:0]    o_tx_data;
  logic          o_busy;
  logic          o_done;

  int         errs = 0;
  int         checks = 0;
  logic [7:0] logq[$];
  int         done_cnt = 0;
  int         dbl = 0;
  int         nreads = 0;
  int         first_rd = -1;
  int         reads[NW];
  logic       stall = 0;
  logic       prev_start = 0;
  logic [1407:0] snap;

  debug_dump_sequencer #(.MEM_WORDS(NW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_start              (i_start),
    .i_clk_count          (i_clk_count),
    .i_snapshot           (i_snapshot),
    .i_mem_data           (i_mem_data),
    .i_tx_done            (i_tx_done),
    .o_debug_read_data    (o_debug_read_data),
    .o_debug_read_address (o_debug_read_address),
    .o_tx_start           (o_tx_start),
    .o_tx_data            (o_tx_data),
    .o_busy               (o_busy),
    .o_done               (o_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Observe DUT outputs mid-cycle; serve debug reads one cycle later
  initial begin
    i_mem_data = '0;
    forever begin
      @(negedge clk);
      if (o_tx_start) begin
        logq.push_back(o_tx_data);
        if (prev_start) dbl++;
      end
      prev_start = o_tx_start;
      if (o_done) done_cnt++;
      if (o_debug_read_data) begin
        if (first_rd < 0) first_rd = logq.size();
        nreads++;
        if (o_debug_read_address < 10'(NW))
          reads[o_debug_read_address]++;
        i_mem_data = 32'(o_debug_read_address) * 32'h01010101;
      end
    end
  end

  // UART model: busy (done=0) for a couple of cycles per launched byte
  initial begin
    i_tx_done = 1'b1;
    forever begin
      @(negedge clk);
      if (o_tx_start && !stall) begin
        @(posedge clk);
        #1 i_tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 i_tx_done = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c = 0;
    while (logq.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("wait_bytes", 32'(logq.size() >= n), 32'd1);
  endtask

  task automatic clear_logs();
    logq.delete();
    done_cnt = 0;
    dbl      = 0;
    nreads   = 0;
    first_rd = -1;
    for (int i = 0; i < NW; i++) reads[i] = 0;
  endtask

  initial begin
    int bad;
    int c;
    logic [7:0] x;
    rst         = 1'b0;
    i_start     = 1'b0;
    i_clk_count = '0;
    i_snapshot  = '0;
    for (int i = 0; i < NW; i++) reads[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_tx_start", 32'(o_tx_start), 0);
    chk("rst_tx_data", 32'(o_tx_data), 0);
    chk("rst_rd", 32'(o_debug_read_data), 0);
    chk("rst_addr", 32'(o_debug_read_address), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < SNB; i++) snap[i*8 +: 8] = 8'(i);
    snap[7:0]         = 8'hA5;
    snap[1407:1400]   = 8'h3C;
    i_clk_count = 32'h11223344;
    i_snapshot  = snap;

    // Abort after three bytes with an asynchronous reset
    pulse_start();
    chk("latency_tx_start", 32'(o_tx_start), 1);
    chk("latency_busy", 32'(o_busy), 1);
    chk("latency_byte0", 32'(o_tx_data), 32'h44);
    wait_bytes(3, 100);
    #2 rst = 1'b0;
    #1;
    chk("abort_tx_start", 32'(o_tx_start), 0);
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_tx_data", 32'(o_tx_data), 0);
    chk("abort_rd", 32'(o_debug_read_data), 0);
    chk("abort_done", 32'(o_done), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 0);

    // Full dump; captured inputs change right after the start
    clear_logs();
    pulse_start();
    i_clk_count = 32'hDEADBEEF;
    i_snapshot  = '1;
    wait_bytes(20, 400);
    pulse_start();
    c = 0;
    while (done_cnt == 0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", 32'(done_cnt), 1);
    @(negedge clk);
    chk("idle_busy", 32'(o_busy), 0);
    repeat (20) @(negedge clk);
    chk("done_once", 32'(done_cnt), 1);
    chk("byte_count", 32'(logq.size()), 32'(TOTAL));
    if (logq.size() >= TOTAL) begin
      chk("hdr0", 32'(logq[0]), 32'h44);
      chk("hdr1", 32'(logq[1]), 32'h33);
      chk("hdr2", 32'(logq[2]), 32'h22);
      chk("hdr3", 32'(logq[3]), 32'h11);
      chk("snap_first", 32'(logq[4]), 32'hA5);
      chk("snap_last", 32'(logq[4 + SNB - 1]), 32'h3C);
      bad = 0;
      for (int i = 0; i < SNB; i++)
        if (logq[4 + i] !== snap[i*8 +: 8]) bad++;
      chk("snap_all", 32'(bad), 0);
      bad = 0;
      for (int w = 0; w < NW; w++)
        for (int b = 0; b < 4; b++)
          if (logq[4 + SNB + w*4 + b] !== 8'(w)) bad++;
      chk("mem_bytes", 32'(bad), 0);
      chk("mem_tail", 32'(logq[4 + SNB + NW*4 - 1]), 32'h03);
`ifdef DUMP_CHECKSUM_EN
      x = '0;
      for (int i = 0; i < TOTAL - 1; i++) x = x ^ logq[i];
      chk("checksum", 32'(logq[TOTAL - 1]), 32'(x));
`endif
    end
    chk("first_read_pos", 32'(first_rd), 32'(4 + SNB));
    chk("read_count", 32'(nreads), 32'(NW));
    for (int i = 0; i < NW; i++) chk("read_addr_once", 32'(reads[i]), 1);
    chk("single_cycle_start", 32'(dbl), 0);

    // UART never goes busy: sequencer must park after one launch
    stall = 1'b1;
    repeat (3) @(negedge clk);
    clear_logs();
    i_clk_count = 32'h0000005A;
    pulse_start();
    repeat (40) @(negedge clk);
    chk("stall_one_byte", 32'(logq.size()), 1);
    chk("stall_busy", 32'(o_busy), 1);
    pulse_start();
    repeat (20) @(negedge clk);
    chk("stall_restart_ignored", 32'(logq.size()), 1);
    chk("stall_tx_start", 32'(o_tx_start), 0);
    if (logq.size() > 0) chk("stall_byte", 32'(logq[0]), 32'h5A);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/debug_dump_sequencer.md
Name: debug_dump_sequencer

Overview:
- Streams a frozen debug image of the pipeline to the UART TX after the debug FSM halts the datapath.
- Image order: clock-cycle counter, then the concatenated register-file/latch snapshot, then data memory words read through the datapath debug read port.
- Sits between the debug FSM (start/done), the datapath debug outputs, and the UART transmitter. It owns the tx_start/tx_data pair while a dump is active.

Parameters:
- UART_BITS, 8, UART byte width.
- PROC_BITS, 32, data memory word width; multiple of UART_BITS.
- DATA_ADDRS_BITS, 10, data memory address width.
- CLK_COUNTER_BITS, 32, cycle counter width; multiple of UART_BITS.
- SNAP_BITS, 1024+64+128+128+64, concatenation {mem_wb, ex_mem, id_ex, if_id, rf_regs}; multiple of UART_BITS.
- MEM_WORDS, 32, number of data memory words dumped (addresses 0..MEM_WORDS-1); 1..2^DATA_ADDRS_BITS.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- i_start  in  1  one-cycle request to begin a dump
- i_clk_count  in  CLK_COUNTER_BITS  datapath cycle counter
- i_snapshot  in  SNAP_BITS  concatenated RF/latch signals
- i_mem_data  in  PROC_BITS  debug read data, valid 1 cycle after request
- i_tx_done  in  1  UART TX idle/done level (1 = idle)
- o_debug_read_data  out  1  debug memory read enable
- o_debug_read_address  out  DATA_ADDRS_BITS  debug read word address
- o_tx_start  out  1  one-cycle byte launch pulse
- o_tx_data  out  UART_BITS  byte to transmit
- o_busy  out  1  dump in progress
- o_done  out  1  one-cycle pulse when the last byte completes

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, counters 0. Reset mid-dump aborts immediately; no o_done is issued.
- IDLE: on i_start=1, capture i_clk_count and i_snapshot into shift registers, set o_busy=1, go to SEND_HDR. i_start while busy is ignored.
- Byte launch rule, common to all send states:
  - Launch only when i_tx_done=1.
  - Assert o_tx_start for exactly one cycle, with o_tx_data held stable from that cycle until the next launch.
  - Then go to WAIT_LOW (wait for i_tx_done=0), then WAIT_HIGH (wait for i_tx_done=1).
  - Bytes are sent LSB byte first.
- SEND_HDR: sends CLK_COUNTER_BITS/8 bytes, then SEND_SNAP.
- SEND_SNAP: sends SNAP_BITS/8 bytes, then MEM_REQ.
- MEM_REQ: o_debug_read_data=1 and o_debug_read_address=word index for one cycle, then MEM_LATCH.
- MEM_LATCH: capture i_mem_data, then SEND_MEM.
- SEND_MEM: sends PROC_BITS/8 bytes.
  - If the word index equals MEM_WORDS-1, go to FINISH; otherwise increment the index and return to MEM_REQ.
  - The index does not wrap past MEM_WORDS-1.
- FINISH: o_done=1 for one cycle, o_busy=0, return to IDLE.
- Latency: first o_tx_start occurs 1 cycle after i_start when i_tx_done=1.
- Total bytes: CLK_COUNTER_BITS/8 + SNAP_BITS/8 + MEM_WORDS*PROC_BITS/8 (+1 with the checksum).
- Inputs i_clk_count and i_snapshot may change after capture without affecting the dump.
- If i_tx_done stays 1 after a launch, the sequencer waits in WAIT_LOW indefinitely; there is no timeout.
- o_debug_read_data is 0 in all states except MEM_REQ.

Optional Feature:
- DUMP_CHECKSUM_EN defined: an 8-bit XOR of every transmitted byte is accumulated (cleared on start). It is sent as a final byte after the last memory byte, before FINISH.
- Without the macro: no checksum byte is sent and no accumulator logic is present.

Decomposition:
- Shared package/constants header: state encoding, derived byte counts (HDR_BYTES, SNAP_BYTES, WORD_BYTES), and the snapshot field order/offsets.
- One natural sub-module: byte_shift_tx — loads a wide word, performs the launch/WAIT_LOW/WAIT_HIGH handshake per byte, and signals last-byte-done. It is instantiated once with a width multiplexed by state.

Test Plan:
- Reset held low mid-dump, after 3 bytes -> all outputs 0 immediately; after release, i_start restarts with byte 0 of the counter.
- i_clk_count=32'h11223344, i_start pulse, tx model toggling i_tx_done -> first four bytes 44,33,22,11, one o_tx_start pulse each.
- i_snapshot LSB byte=A5, MSB byte=3C -> byte 5 is A5; last snapshot byte is 3C, before any o_debug_read_data.
- Memory model word[n]=n*0x01010101, MEM_WORDS=4 -> addresses 0,1,2,3 each asserted once; stream ends 03 03 03 03; then o_done pulse, o_busy=0.
- i_tx_done held 1 after a launch -> no further o_tx_start; asserting i_start again mid-dump has no effect.
- With DUMP_CHECKSUM_EN -> final extra byte equals the XOR of all prior bytes; without it, the byte count equals the formula above.
